// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory arbiter: FSM states, port-owner encoding, default widths.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // True in the single completion cycle belonging to the given port.
  function automatic logic resp_for(input state_e st, input owner_e own, input owner_e port);
    return (st == S_RESP) && (own == port);
  endfunction

endpackage

// File: rtl/arb_grant.sv
// Two-port grant select: fixed data-over-inst priority, or round-robin when
// ARB_ROUND_ROBIN_EN is defined (the last-granted port loses a tie).
module arb_grant
  import cpu_mem_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  owner_e last_grant,
  output logic   grant_inst,
  output logic   grant_data
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (inst_req && data_req) begin
      if (last_grant == OWN_DATA) grant_inst = 1'b1;
      else                        grant_data = 1'b1;
    end else begin
      grant_inst = inst_req;
      grant_data = data_req;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == OWN_DATA);

  always_comb begin
    grant_data = data_req;
    grant_inst = inst_req & ~data_req;
  end
`endif

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the fetch and data ports onto one req/addr_ok/data_ok memory bus.
// Tie-break policy is selected by ARB_ROUND_ROBIN_EN (see arb_grant).
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_data_ok,
  output logic                inst_busy,
  output logic                data_busy,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wen,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int WEN_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [WEN_W-1:0]    wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                bus_req_q, bus_req_d;
  logic                inst_ok_q, inst_ok_d;
  logic                data_ok_q, data_ok_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                capture;
  logic                grant_inst, grant_data;

  // owner_q doubles as the last-grant register: it is only rewritten on a grant.
  arb_grant u_arb_grant (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (owner_q),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          owner_d = OWN_DATA;
          addr_d  = data_addr;
          wr_d    = data_wr;
          wen_d   = data_wen;
          wdata_d = data_wdata;
          state_d = S_ADDR;
        end else if (grant_inst) begin
          owner_d = OWN_INST;
          addr_d  = inst_addr;
          wr_d    = 1'b0;
          wen_d   = '0;
          wdata_d = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        // A data_ok without an accepted address phase belongs to nobody.
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            capture = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus_data_ok) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      if (owner_q == OWN_DATA) data_rdata_d = bus_rdata;
      else                     inst_rdata_d = bus_rdata;
    end

    bus_req_d = (state_d == S_ADDR);
    inst_ok_d = resp_for(state_d, owner_d, OWN_INST);
    data_ok_d = resp_for(state_d, owner_d, OWN_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wen_q        <= '0;
      wdata_q      <= '0;
      bus_req_q    <= 1'b0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      bus_req_q    <= bus_req_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_wr       = wr_q;
  assign bus_wen      = wen_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign inst_data_ok = inst_ok_q;
  assign data_data_ok = data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;

  assign inst_busy = inst_req & ~resp_for(state_q, owner_q, OWN_INST);
  assign data_busy = data_req & ~resp_for(state_q, owner_q, OWN_DATA);

  a_one_owner_pulse: assert property (@(posedge clk) !(inst_ok_q && data_ok_q));
  a_pulse_single:    assert property (@(posedge clk) disable iff (rst)
                                      (inst_ok_q || data_ok_q) |=> !(inst_ok_q || data_ok_q));

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a transaction-level model is compared every
// cycle, and literal expectations pin latency, priority, reset and tie-break policy.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_data_ok;
  logic        inst_busy, data_busy;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  cpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok),
    .inst_busy(inst_busy), .data_busy(data_busy),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: one outstanding transfer, address phase flag, completion pulse.
  bit          m_act = 0, m_acc = 0, m_pulse = 0, m_own_data = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;
  logic        m_wr = 0;
  logic [3:0]  m_wen = '0;

  task automatic m_finish();
    if (m_own_data) m_drd = bus_rdata;
    else            m_ird = bus_rdata;
    m_act   = 0;
    m_pulse = 1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_act = 0; m_acc = 0; m_pulse = 0; m_own_data = 0;
      m_ird = '0; m_drd = '0;
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (!m_act) begin
      if (inst_req || data_req) begin
        m_own_data = data_req && (!inst_req || !RR || !m_own_data);
        m_act = 1;
        m_acc = 0;
        if (m_own_data) begin
          m_addr = data_addr; m_wr = data_wr; m_wen = data_wen; m_wdata = data_wdata;
        end else begin
          m_addr = inst_addr; m_wr = 0; m_wen = '0; m_wdata = '0;
        end
      end
    end else if (!m_acc) begin
      if (bus_addr_ok) begin
        m_acc = 1;
        if (bus_data_ok) m_finish();
      end
    end else if (bus_data_ok) begin
      m_finish();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_req", {31'd0, bus_req}, {31'd0, m_act && !m_acc});
      if (m_act && !m_acc) begin
        check("bus_addr", bus_addr, m_addr);
        check("bus_wr", {31'd0, bus_wr}, {31'd0, m_wr});
        check("bus_wen", {28'd0, bus_wen}, {28'd0, m_wen});
        if (m_wr) check("bus_wdata", bus_wdata, m_wdata);
      end
      check("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, m_pulse && !m_own_data});
      check("data_data_ok", {31'd0, data_data_ok}, {31'd0, m_pulse && m_own_data});
      check("inst_rdata", inst_rdata, m_ird);
      check("data_rdata", data_rdata, m_drd);
      check("inst_busy", {31'd0, inst_busy}, {31'd0, inst_req && !(m_pulse && !m_own_data)});
      check("data_busy", {31'd0, data_busy}, {31'd0, data_req && !(m_pulse && m_own_data)});
    end
  end

  task automatic do_reset();
    rst = 1; inst_req = 0; data_req = 0; data_wr = 0; data_wen = '0;
    bus_addr_ok = 0; bus_data_ok = 0;
    step(); step();
    rst = 0;
  endtask

  int bus_req_cnt, pulse_cnt, pulse_cyc;
  logic [3:0] gseq;
  int gidx;
  bit prev_req;

  initial begin
    // Reset state
    step(); chk_en = 1; step();
    check("rst bus_req", {31'd0, bus_req}, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_wr_wen", {27'd0, bus_wr, bus_wen}, 32'd0);
    check("rst rdata", inst_rdata | data_rdata, 32'd0);
    check("rst ok_busy", {28'd0, inst_data_ok, data_data_ok, inst_busy, data_busy}, 32'd0);
    rst = 0;

    // Single load, minimum latency
    data_req = 1; data_wr = 0; data_wen = 4'h0; data_addr = 32'h1000;
    step();
    check("t1 c1 bus_req", {31'd0, bus_req}, 32'd1);
    check("t1 c1 bus_addr", bus_addr, 32'h1000);
    check("t1 c1 data_busy", {31'd0, data_busy}, 32'd1);
    bus_addr_ok = 1;
    step();
    check("t1 c2 bus_req", {31'd0, bus_req}, 32'd0);
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
    step();
    check("t1 c3 data_data_ok", {31'd0, data_data_ok}, 32'd1);
    check("t1 c3 data_rdata", data_rdata, 32'hDEADBEEF);
    bus_data_ok = 0; data_req = 0;
    step();
    check("t1 c4 data_data_ok", {31'd0, data_data_ok}, 32'd0);
    check("t1 c4 data_busy", {31'd0, data_busy}, 32'd0);
    check("t1 c4 rdata hold", data_rdata, 32'hDEADBEEF);

    // Simultaneous requests: store first, then fetch with combined handshake
    do_reset();
    inst_req = 1; inst_addr = 32'h100;
    data_req = 1; data_wr = 1; data_wen = 4'b0011; data_addr = 32'h2000; data_wdata = 32'h12345678;
    step();
    check("t2 c1 bus_wr", {31'd0, bus_wr}, 32'd1);
    check("t2 c1 bus_wen", {28'd0, bus_wen}, 32'h3);
    check("t2 c1 bus_addr", bus_addr, 32'h2000);
    bus_addr_ok = 1;
    step();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0;
    step();
    check("t2 c3 data_data_ok", {31'd0, data_data_ok}, 32'd1);
    check("t2 c3 inst_busy", {31'd0, inst_busy}, 32'd1);
    bus_data_ok = 0; data_req = 0; data_wr = 0; data_wen = '0;
    step();
    check("t2 c4 bus_req", {31'd0, bus_req}, 32'd0);
    step();
    check("t2 c5 inst grant", {bus_req, bus_wr, bus_wen, bus_addr[25:0]}, {1'b1, 1'b0, 4'h0, 26'h100});
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
    step();
    check("t2 c6 inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    check("t2 c6 inst_rdata", inst_rdata, 32'hCAFEF00D);
    check("t2 c6 bus_req", {31'd0, bus_req}, 32'd0);
    bus_addr_ok = 0; bus_data_ok = 0; inst_req = 0;
    step();
    check("t2 c7 inst_data_ok", {31'd0, inst_data_ok}, 32'd0);

    // Slow bus with a stray data_ok in the address phase and a moving inst_addr
    do_reset();
    inst_req = 1; inst_addr = 32'h400;
    bus_req_cnt = 0; pulse_cnt = 0; pulse_cyc = -1;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (bus_req) begin
        bus_req_cnt++;
        check("t3 bus_addr stable", bus_addr, 32'h400);
      end
      if (inst_data_ok) begin
        pulse_cnt++;
        pulse_cyc = c;
        inst_req = 0;
      end
      if (c == 2) inst_addr = 32'h888;
      bus_addr_ok = (c == 6);
      bus_data_ok = (c == 3) || (c == 13);
      bus_rdata   = (c == 13) ? 32'h0BADF00D : 32'hFFFFFFFF;
    end
    bus_addr_ok = 0; bus_data_ok = 0;
    check("t3 bus_req cycles", bus_req_cnt, 32'd6);
    check("t3 pulse count", pulse_cnt, 32'd1);
    check("t3 pulse cycle", pulse_cyc, 32'd14);
    check("t3 inst_rdata", inst_rdata, 32'h0BADF00D);

    // Reset while waiting in the data phase
    do_reset();
    data_req = 1; data_wr = 0; data_addr = 32'h3000;
    step();
    bus_addr_ok = 1;
    step();
    check("t5 c2 bus_req", {31'd0, bus_req}, 32'd0);
    bus_addr_ok = 0; rst = 1; data_req = 0;
    step();
    check("t5 c3 bus_req", {31'd0, bus_req}, 32'd0);
    rst = 0;
    step();
    bus_data_ok = 1; bus_rdata = 32'h00000BAD;
    pulse_cnt = 0;
    for (int c = 5; c <= 7; c++) begin
      step();
      bus_data_ok = 0;
      if (data_data_ok || inst_data_ok) pulse_cnt++;
    end
    check("t5 stray pulses", pulse_cnt, 32'd0);
    check("t5 data_rdata", data_rdata, 32'd0);

    // Both ports held: tie-break sequence
    do_reset();
    inst_req = 1; inst_addr = 32'h500;
    data_req = 1; data_wr = 0; data_addr = 32'h6000;
    gseq = '0; gidx = 0; prev_req = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (bus_req && !prev_req && gidx < 4) begin
        gseq[gidx] = (bus_addr == 32'h6000);
        gidx++;
      end
      prev_req = bus_req;
      bus_addr_ok = bus_req; bus_data_ok = bus_req; bus_rdata = 32'hA0000000 + c;
    end
    bus_addr_ok = 0; bus_data_ok = 0; inst_req = 0; data_req = 0;
    check("t6 grant count", gidx, 32'd4);
`ifdef ARB_ROUND_ROBIN_EN
    check("t6 grant order", {28'd0, gseq}, 32'b0101);
`else
    check("t6 grant order", {28'd0, gseq}, 32'b1111);
`endif
    step(); step();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Arbitrates the core's instruction-fetch port (F stage) and data port (M stage) onto one shared SRAM-like bus with a req/addr_ok/data_ok handshake. It sits between the mips core and the single external memory port. It returns per-port completion pulses and busy flags, which the hazard unit turns into pipeline stalls.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; write-enable is DATA_W/8 bits.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
inst_req  in  1  fetch request; held until inst_data_ok.
inst_addr  in  ADDR_W  fetch address (pcF).
inst_rdata  out  DATA_W  fetch data; valid while inst_data_ok=1.
inst_data_ok  out  1  one-cycle fetch-complete pulse.
data_req  in  1  load/store request; held until data_data_ok.
data_wr  in  1  1 = store, 0 = load.
data_wen  in  DATA_W/8  byte enables (memwriteM).
data_addr  in  ADDR_W  data address (aluoutM).
data_wdata  in  DATA_W  store data (writedataM).
data_rdata  out  DATA_W  load data (readdataM); valid while data_data_ok=1.
data_data_ok  out  1  one-cycle data-complete pulse.
inst_busy  out  1  inst_req=1 and completion not yet pulsed.
data_busy  out  1  data_req=1 and completion not yet pulsed.
bus_req  out  1  bus request.
bus_wr  out  1  bus write.
bus_wen  out  DATA_W/8  bus byte enables.
bus_addr  out  ADDR_W  bus address.
bus_wdata  out  DATA_W  bus write data.
bus_addr_ok  in  1  bus accepted the address phase.
bus_data_ok  in  1  bus completed the transaction.
bus_rdata  in  DATA_W  bus read data; valid while bus_data_ok=1.

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP. The register `owner` (INST/DATA) records the granted port.
- IDLE:
  - If any request is pending, grant it: latch addr, wr, wen and wdata into bus registers, set owner, go to ADDR.
  - Priority is data over inst (fixed).
  - Instruction requests always drive wr=0 and wen=0.
- ADDR:
  - bus_req=1; bus_* outputs come from the latched registers, so later requester changes are ignored.
  - bus_addr_ok=1 → DATA.
  - bus_addr_ok=1 and bus_data_ok=1 in the same cycle → latch bus_rdata, go to RESP.
- DATA:
  - bus_req=0; wait for bus_data_ok.
  - On bus_data_ok: latch bus_rdata into the owner's rdata register, go to RESP.
- RESP:
  - Pulse the owner's *_data_ok for exactly one cycle, then go to IDLE.
  - A new grant can be issued the next cycle, in IDLE.
- Minimum latency: req at cycle 0 → bus_req at cycle 1 → (addr_ok at 1, data_ok at 2) → *_data_ok at cycle 3.
- A port with a pending request is granted no earlier than the cycle after its completion pulse.
- *_busy = *_req & ~(owner matches the port & state==RESP). These are combinational.
- If a requester drops req mid-transaction, the arbiter still completes the transaction and pulses data_ok. The requester must ignore that pulse.
- bus_data_ok in IDLE or ADDR without a matching address phase is ignored.
- rdata registers hold their value between pulses.
- Reset values: state=IDLE, owner=INST, and all outputs 0 (bus_*, *_rdata, *_data_ok, *_busy follow from req).
- Reset mid-transaction:
  - Return to IDLE immediately and drop bus_req.
  - Any late bus_data_ok from the aborted transfer is ignored.
  - The bus must be idle before the core deasserts rst; this is a system-level rule.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: the port granted last gets lowest priority. After a data grant, inst wins a tie; after an inst grant, data wins a tie. The last-grant register resets to INST, so data wins the first tie.
- Undefined: data always wins a tie. inst can starve while data_req is held continuously.

Decomposition:
- Package cpu_mem_pkg:
  - state enum: IDLE, ADDR, DATA, RESP.
  - owner encoding: INST=0, DATA=1.
  - default widths.
- One natural sub-module, `arb_grant`: combinational priority/round-robin select producing grant_inst and grant_data from the two requests and the last-grant register. The FSM and datapath live in the top.

Test Plan:
- Single load: data_req=1, data_addr=0x1000, bus_addr_ok at cycle 1, bus_data_ok at cycle 2 with bus_rdata=0xDEADBEEF → data_data_ok pulses at cycle 3 with data_rdata=0xDEADBEEF; data_busy falls at cycle 4.
- Simultaneous requests: inst_req and data_req at cycle 0, data store wen=4'b0011 at 0x2000 → first bus_req has bus_wr=1, bus_wen=0011, bus_addr=0x2000; instruction grant follows after data_data_ok.
- Slow bus: bus_addr_ok delayed 5 cycles, bus_data_ok delayed 7 more → bus_req stays high for 6 cycles and bus_addr is stable throughout; exactly one inst_data_ok pulse.
- Combined handshake: bus_addr_ok=1 and bus_data_ok=1 in the same cycle → RESP the next cycle, with no DATA state.
- Reset during DATA: rst at cycle 2 → bus_req=0 and state=IDLE at cycle 3; a stray bus_data_ok at cycle 4 produces no *_data_ok pulse.
- ARB_ROUND_ROBIN_EN: inst_req and data_req both held high → grants alternate data, inst, data, inst. Without the macro, inst is never granted.
